div_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32M divide/remainder ops (DIV, DIVU, REM, REMU) in the EX stage.
- MUL-class ops stay single-cycle in the ALU. Divide ops are intercepted here and run as a restoring shift-subtract loop, one quotient bit per cycle.
- Holds the pipeline via `stall` until the result is ready.
- Control/datapath boundary: decode supplies the 5-bit ALU op; this block owns the iteration FSM, counter and sign fix-up.

---
 rtl/div_sequencer.sv | 134 +++++++++++++
 tb/tb_div_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer for the EX stage.
// Restoring shift-subtract, one quotient bit per cycle, with sign fix-up and special cases.
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d, result_q, result_d;
    logic            op_rem_q, op_rem_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic            busy_q, busy_d, valid_q, valid_d;

    logic            is_div, is_signed, accept, sign1, sign2;
    logic [XLEN-1:0] abs1, abs2;
    logic [XLEN:0]   rem_sh, trial;
    logic            unused_op_bit;

    assign unused_op_bit = alu_op[4];
    assign is_div    = alu_op[3] & alu_op[2];
    assign is_signed = ~alu_op[0];
    assign accept    = (state_q == IDLE) & start & is_div & ~flush;
    assign sign1     = is_signed & data1[XLEN-1];
    assign sign2     = is_signed & data2[XLEN-1];
    assign abs1      = sign1 ? -data1 : data1;
    assign abs2      = sign2 ? -data2 : data2;

    // rem_q < divisor, so the shifted remainder needs one extra bit; trial[XLEN] is the borrow.
    assign rem_sh = {rem_q, quot_q[XLEN-1]};
    assign trial  = rem_sh - {1'b0, dvsr_q};

    assign stall        = ~reset & (accept | (state_q == RUN));
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvsr_d   = dvsr_q;
        op_rem_d = op_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_rem_d = alu_op[1];
                    q_neg_d  = sign1 ^ sign2;
                    r_neg_d  = sign1;
                    dvsr_d   = abs2;
                    cnt_d    = '0;
                    if (data2 == '0) begin
                        quot_d  = '1;
                        rem_d   = data1;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = DONE;
                    end else if (is_signed && data1 == MIN_NEG && data2 == '1) begin
                        quot_d  = MIN_NEG;
                        rem_d   = '0;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        quot_d  = abs1;
                        rem_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                quot_d = {quot_q[XLEN-2:0], ~trial[XLEN]};
                rem_d  = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN-1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (flush && state_q != IDLE) state_d = IDLE;
        valid_d = (state_d == DONE);
        busy_d  = (state_d == RUN);
        // Result is formed on the edge entering DONE so it is registered alongside result_valid.
        if (state_d == DONE)
            result_d = op_rem_d ? (r_neg_d ? -rem_d : rem_d) : (q_neg_d ? -quot_d : quot_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            op_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvsr_q   <= dvsr_d;
            op_rem_q <= op_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed divides push expected results, a monitor checks them.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [4:0]  alu_op;
    logic [31:0] data1, data2;
    logic        stall, busy, result_valid;
    logic [31:0] result;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    div_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_op(alu_op),
        .data1(data1), .data2(data2), .flush(flush),
        .stall(stall), .busy(busy), .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("result", result, e);
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        alu_op = {2'b01, f3};
        data1  = a;
        data2  = b;
    endtask

    // Drives one divide from an IDLE cycle and returns at the DONE cycle's negedge.
    task automatic run_div(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
        int n;
        @(negedge clk);
        exp_q.push_back(exp);
        issue(f3, a, b);
        #1 chk({name, "_stall_T"}, {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        data1 = $urandom;
        data2 = $urandom;
        n = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
        chk({name, "_stall_cycles"}, n, exp_stall);
        chk({name, "_valid_at_done"}, {31'd0, result_valid}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; alu_op = '0; data1 = '0; data2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        issue(F_DIV, 32'd10, 32'd2);
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        run_div("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_div("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_div("div_m7_2",   F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_div("rem_m7_2",   F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_div("rem_7_m2",   F_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_div("div_ovf",    F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_div("rem_ovf",    F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_div("div_5_0",    F_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_div("remu_5_0",   F_REMU, 32'd5, 32'd0, 32'd5, 1);

        // Flush mid-RUN: nothing expected from this op, prior result (5) must hold.
        @(negedge clk);
        issue(F_DIVU, 32'd1000, 32'd10);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("flush_busy_in_run", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy_drop", {31'd0, busy}, 32'd0);
        chk("flush_stall_drop", {31'd0, stall}, 32'd0);
        chk("flush_result_hold", result, 32'd5);
        repeat (3) @(negedge clk);
        chk("flush_result_hold_late", result, 32'd5);

        // flush together with start in IDLE: not accepted.
        issue(F_DIVU, 32'd9, 32'd3);
        flush = 1'b1;
        #1 chk("flush_start_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);

        run_div("divu_9_3", F_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Back-to-back: second op issued in the IDLE cycle right after DONE.
        run_div("b2b_50_5", F_DIVU, 32'd50, 32'd5, 32'd10, 33);
        run_div("b2b_81_9", F_DIVU, 32'd81, 32'd9, 32'd9, 33);

        // MUL is ignored.
        @(negedge clk);
        start = 1'b1; alu_op = 5'b01000; data1 = 32'd6; data2 = 32'd7;
        #1 chk("mul_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1 chk("mul_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-RUN clears everything.
        issue(F_DIVU, 32'd1000, 32'd10);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_run_busy", {31'd0, busy}, 32'd0);
        chk("rst_run_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_run_result", result, 32'd0);
        chk("rst_run_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0; flush = 1'b0;

        run_div("post_rst_div", F_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
